// File: rtl/vlc_pack_fifo.sv
// Byte-to-word packing FIFO: gathers bytes into BYTES_PER_WORD-byte words and queues them
// in a first-word-fall-through circular buffer, with a zero-padded partial-word flush.
module vlc_pack_fifo #(
  parameter int BYTES_PER_WORD = 4,
  parameter int DEPTH          = 64,
  parameter bit MSB_FIRST      = 1'b1,
  localparam int W             = 8 * BYTES_PER_WORD,
  localparam int OBW           = $clog2(BYTES_PER_WORD + 1),
  localparam int LW            = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  output logic [W-1:0]   out_data,
  output logic [OBW-1:0] out_bytes,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LW-1:0]  level,
  output logic           flush_busy
);
  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES_PER_WORD - 1);

  logic [W-1:0]   mem_data_q  [DEPTH];
  logic [OBW-1:0] mem_bytes_q [DEPTH];

  logic [W-1:0]   acc_q, acc_d, acc_ins;
  logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]  level_q, level_d;
  logic           flush_busy_q, flush_busy_d;

  logic           full, empty, accept, pop, can_push, push;
  logic [W-1:0]   push_data;
  logic [OBW-1:0] push_bytes, held_bytes;

  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign in_ready   = !flush_busy_q && !(full && (acc_cnt_q == LAST_IDX));
  assign accept     = in_valid && in_ready;
  assign pop        = !empty && out_ready;
  assign can_push   = !full || pop;
  assign held_bytes = OBW'(acc_cnt_q) + OBW'(accept);

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_data_q[rd_ptr_q];
  assign out_bytes  = empty ? '0 : mem_bytes_q[rd_ptr_q];
  assign level      = level_q;
  assign flush_busy = flush_busy_q;

  // Accumulator with the incoming byte dropped into its lane for the current position
  always_comb begin
    acc_ins = acc_q;
    if (accept) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (acc_cnt_q == CW'(k)) begin
          acc_ins[(MSB_FIRST ? (BYTES_PER_WORD - 1 - k) : k) * 8 +: 8] = in_data;
        end
      end
    end
  end

  always_comb begin
    push         = 1'b0;
    push_data    = acc_ins;
    push_bytes   = OBW'(BYTES_PER_WORD);
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    flush_busy_d = flush_busy_q;
    if (flush_busy_q) begin
      // A parked flush holds the padded word in the accumulator until a slot frees up
      if (can_push) begin
        push         = 1'b1;
        push_bytes   = OBW'(acc_cnt_q);
        acc_d        = '0;
        acc_cnt_d    = '0;
        flush_busy_d = 1'b0;
      end
    end else if (accept && (acc_cnt_q == LAST_IDX)) begin
      push      = 1'b1;
      acc_d     = '0;
      acc_cnt_d = '0;
    end else if (flush && ((acc_cnt_q != '0) || accept)) begin
      if (can_push) begin
        push       = 1'b1;
        push_bytes = held_bytes;
        acc_d      = '0;
        acc_cnt_d  = '0;
      end else begin
        flush_busy_d = 1'b1;
        acc_d        = acc_ins;
        acc_cnt_d    = CW'(held_bytes);
      end
    end else if (accept) begin
      acc_d     = acc_ins;
      acc_cnt_d = acc_cnt_q + CW'(1);
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      flush_busy_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      level_q      <= level_d;
      flush_busy_q <= flush_busy_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage carries no reset; stale entries are never visible because level gates the head
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q]  <= push_data;
      mem_bytes_q[wr_ptr_q] <= push_bytes;
    end
  end

  a_level_bounded : assert property (@(posedge clk) disable iff (rst) level_q <= LW'(DEPTH));
  a_no_overflow   : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_vlc_pack_fifo.sv
// Scoreboard bench for vlc_pack_fifo: one MSB-first and one LSB-first instance share stimulus,
// expected words are queued at issue time and a negedge monitor compares every popped word.
module tb_vlc_pack_fifo;
  localparam int BPW   = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  inData = 8'h00;
  logic        inValid = 1'b0;
  logic        flush = 1'b0;
  logic        outReady = 1'b0;

  logic        inReadyM, inReadyL, outValidM, outValidL, flushBusyM, flushBusyL;
  logic [31:0] outDataM, outDataL;
  logic [2:0]  outBytesM, outBytesL;
  logic [6:0]  levelM, levelL;

  int checks = 0;
  int errors = 0;

  logic [31:0] qDataM[$];
  logic [31:0] qDataL[$];
  logic [2:0]  qBytesM[$];
  logic [2:0]  qBytesL[$];

  always #5 clk = ~clk;

  vlc_pack_fifo #(.BYTES_PER_WORD(BPW), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReadyM),
    .flush(flush), .out_data(outDataM), .out_bytes(outBytesM), .out_valid(outValidM),
    .out_ready(outReady), .level(levelM), .flush_busy(flushBusyM)
  );

  vlc_pack_fifo #(.BYTES_PER_WORD(BPW), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReadyL),
    .flush(flush), .out_data(outDataL), .out_bytes(outBytesL), .out_valid(outValidL),
    .out_ready(outReady), .level(levelL), .flush_busy(flushBusyL)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock edge with the given inputs, then back to idle
  task automatic applyStimulus(input logic [7:0] data, input logic valid, input logic fl,
                               input logic rdy);
    inData   = data;
    inValid  = valid;
    flush    = fl;
    outReady = rdy;
    tick();
    inValid  = 1'b0;
    flush    = 1'b0;
    outReady = 1'b0;
  endtask

  task automatic expectWord(input logic [31:0] msb, input logic [31:0] lsb, input logic [2:0] nb);
    qDataM.push_back(msb);
    qBytesM.push_back(nb);
    qDataL.push_back(lsb);
    qBytesL.push_back(nb);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic rdy);
    checkOutput("in_ready_before_byte", {63'd0, inReadyM}, 64'd1);
    applyStimulus(b, 1'b1, 1'b0, rdy);
  endtask

  function automatic logic [7:0] pat(input int j, input int k);
    return 8'(j * 4 + k + 1);
  endfunction

  task automatic sendPatWord(input int j, input logic lastRdy);
    for (int k = 0; k < BPW; k++) begin
      sendByte(pat(j, k), (k == BPW - 1) ? lastRdy : 1'b0);
    end
    expectWord({pat(j, 0), pat(j, 1), pat(j, 2), pat(j, 3)},
               {pat(j, 3), pat(j, 2), pat(j, 1), pat(j, 0)}, 3'd4);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && outValidM; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("drain_level", {57'd0, levelM}, 64'd0);
  endtask

  // Monitor: a word presented with out_ready high is popped on the coming edge
  always @(negedge clk) begin
    if (!rst && outValidM && outReady) begin
      if (qDataM.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL msb_unexpected_word actual=%0h expected=none", outDataM);
      end else begin
        checkOutput("msb_word", {32'd0, outDataM}, {32'd0, qDataM.pop_front()});
        checkOutput("msb_bytes", {61'd0, outBytesM}, {61'd0, qBytesM.pop_front()});
      end
    end
    if (!rst && outValidL && outReady) begin
      if (qDataL.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL lsb_unexpected_word actual=%0h expected=none", outDataL);
      end else begin
        checkOutput("lsb_word", {32'd0, outDataL}, {32'd0, qDataL.pop_front()});
        checkOutput("lsb_bytes", {61'd0, outBytesL}, {61'd0, qBytesL.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("rst_out_valid", {63'd0, outValidM}, 64'd0);
    checkOutput("rst_out_bytes", {61'd0, outBytesM}, 64'd0);
    checkOutput("rst_out_data", {32'd0, outDataM}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, inReadyM}, 64'd1);
    checkOutput("rst_level", {57'd0, levelM}, 64'd0);
    checkOutput("rst_flush_busy", {63'd0, flushBusyM}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic word assembly in both byte orders
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    sendByte(8'h33, 1'b0);
    checkOutput("partial_no_valid", {63'd0, outValidM}, 64'd0);
    sendByte(8'h44, 1'b0);
    checkOutput("word1_valid", {63'd0, outValidM}, 64'd1);
    checkOutput("word1_msb", {32'd0, outDataM}, 64'h11223344);
    checkOutput("word1_lsb", {32'd0, outDataL}, 64'h44332211);
    checkOutput("word1_bytes", {61'd0, outBytesM}, 64'd4);
    checkOutput("word1_level", {57'd0, levelM}, 64'd1);
    expectWord(32'h11223344, 32'h44332211, 3'd4);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("pop_valid_m", {63'd0, outValidM}, 64'd0);
    checkOutput("pop_valid_l", {63'd0, outValidL}, 64'd0);
    checkOutput("pop_level", {57'd0, levelM}, 64'd0);

    // Flush variants
    sendByte(8'hAA, 1'b0);
    sendByte(8'hBB, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_msb", {32'd0, outDataM}, 64'hAABB0000);
    checkOutput("flush_lsb", {32'd0, outDataL}, 64'h0000BBAA);
    checkOutput("flush_bytes", {61'd0, outBytesM}, 64'd2);
    checkOutput("flush_level", {57'd0, levelM}, 64'd1);
    expectWord(32'hAABB0000, 32'h0000BBAA, 3'd2);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_noop_level", {57'd0, levelM}, 64'd1);
    sendByte(8'hCC, 1'b0);
    applyStimulus(8'hDD, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_with_byte_level", {57'd0, levelM}, 64'd2);
    expectWord(32'hCCDD0000, 32'h0000DDCC, 3'd2);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_complete_level", {57'd0, levelM}, 64'd3);
    checkOutput("flush_complete_busy", {63'd0, flushBusyM}, 64'd0);
    checkOutput("head_stable", {32'd0, outDataM}, 64'hAABB0000);
    expectWord(32'h01020304, 32'h04030201, 3'd4);
    drain(10);

    // Fill to full, then hold a partial word against the full FIFO
    for (int j = 0; j < DEPTH; j++) sendPatWord(j, 1'b0);
    checkOutput("full_level", {57'd0, levelM}, 64'd64);
    checkOutput("full_in_ready_acc0", {63'd0, inReadyM}, 64'd1);
    for (int k = 0; k < 3; k++) sendByte(pat(DEPTH, k), 1'b0);
    checkOutput("full_in_ready_acc3_m", {63'd0, inReadyM}, 64'd0);
    checkOutput("full_in_ready_acc3_l", {63'd0, inReadyL}, 64'd0);
    checkOutput("full_level_acc3", {57'd0, levelM}, 64'd64);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("one_pop_level", {57'd0, levelM}, 64'd63);
    sendByte(pat(DEPTH, 3), 1'b0);
    expectWord({pat(DEPTH, 0), pat(DEPTH, 1), pat(DEPTH, 2), pat(DEPTH, 3)},
               {pat(DEPTH, 3), pat(DEPTH, 2), pat(DEPTH, 1), pat(DEPTH, 0)}, 3'd4);
    checkOutput("word65_level", {57'd0, levelM}, 64'd64);

    // Flush while full parks until a pop frees a slot
    sendByte(8'hE1, 1'b0);
    sendByte(8'hE2, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    expectWord(32'hE1E20000, 32'h0000E2E1, 3'd2);
    checkOutput("busy_set", {63'd0, flushBusyM}, 64'd1);
    checkOutput("busy_in_ready", {63'd0, inReadyM}, 64'd0);
    checkOutput("busy_level", {57'd0, levelM}, 64'd64);
    applyStimulus(8'hEE, 1'b1, 1'b0, 1'b0);
    checkOutput("busy_hold", {63'd0, flushBusyM}, 64'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("busy_clear", {63'd0, flushBusyM}, 64'd0);
    checkOutput("busy_clear_l", {63'd0, flushBusyL}, 64'd0);
    checkOutput("busy_pop_level", {57'd0, levelM}, 64'd64);
    checkOutput("busy_in_ready_back", {63'd0, inReadyM}, 64'd1);
    drain(100);

    // Steady push/pop at level 1 across pointer wrap
    sendPatWord(100, 1'b0);
    checkOutput("steady_start_level", {57'd0, levelM}, 64'd1);
    for (int j = 101; j <= 300; j++) begin
      sendPatWord(j, 1'b1);
      checkOutput("steady_level", {57'd0, levelM}, 64'd1);
    end

    // Reset mid-word discards everything
    sendByte(8'h99, 1'b0);
    sendByte(8'h9A, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid_m", {63'd0, outValidM}, 64'd0);
    checkOutput("midrst_valid_l", {63'd0, outValidL}, 64'd0);
    checkOutput("midrst_level", {57'd0, levelM}, 64'd0);
    qDataM.delete();
    qDataL.delete();
    qBytesM.delete();
    qBytesL.delete();
    tick();
    tick();
    rst = 1'b0;
    sendByte(8'h55, 1'b0);
    sendByte(8'h66, 1'b0);
    sendByte(8'h77, 1'b0);
    sendByte(8'h88, 1'b0);
    checkOutput("post_rst_msb", {32'd0, outDataM}, 64'h55667788);
    checkOutput("post_rst_lsb", {32'd0, outDataL}, 64'h88776655);
    checkOutput("post_rst_bytes", {61'd0, outBytesM}, 64'd4);
    checkOutput("post_rst_level", {57'd0, levelM}, 64'd1);
    expectWord(32'h55667788, 32'h88776655, 3'd4);
    drain(10);

    checkOutput("leftover_msb", 64'(qDataM.size()), 64'd0);
    checkOutput("leftover_lsb", 64'(qDataL.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
